// File: rtl/rv32_periph_master_if.sv
// Signal bundle between the LSU request/response channels and the peripheral slave bus.
// The master modport is the view taken by rv32_periph_master; slave is the environment's view.
interface rv32_periph_master_if #(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDRW-1:0]  req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_strb;

  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  logic              m_en;
  logic              m_wr;
  logic [ADDRW-1:0]  m_addr;
  logic [XLEN-1:0]   m_wdata;
  logic [XLEN/8-1:0] m_strb;
  logic [XLEN-1:0]   m_rdata;
  logic              m_ready;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_strb,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output m_en, m_wr, m_addr, m_wdata, m_strb,
    input  m_rdata, m_ready
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_strb,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  m_en, m_wr, m_addr, m_wdata, m_strb,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/rv32_periph_master.sv
// Single-outstanding LSU-to-peripheral bus initiator; one bus access per accepted request.
// Optional access watchdog enabled by defining RV32_PERIPH_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a request, bus idle
// ACCESS | m_en high, waiting for m_ready (or watchdog expiry)
// RESP   | response presented until the LSU takes it
module rv32_periph_master #(
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  rv32_periph_master_if.master bus,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;

`ifdef RV32_PERIPH_MASTER_TIMEOUT_EN
  localparam int CNTW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] cnt;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      busy           <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.m_en       <= 1'b0;
      bus.m_wr       <= 1'b0;
      bus.m_addr     <= '0;
      bus.m_wdata    <= '0;
      bus.m_strb     <= '0;
`ifdef RV32_PERIPH_MASTER_TIMEOUT_EN
      cnt            <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            // Misaligned requests never reach the bus.
            if (bus.req_addr[1:0] != 2'b00) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              state       <= ACCESS;
              bus.m_en    <= 1'b1;
              bus.m_wr    <= bus.req_wr;
              bus.m_addr  <= bus.req_addr;
              bus.m_wdata <= bus.req_wdata;
              bus.m_strb  <= bus.req_wr ? bus.req_strb : '0;
`ifdef RV32_PERIPH_MASTER_TIMEOUT_EN
              cnt         <= '0;
`endif
            end
          end
        end

        ACCESS: begin
          // Drop m_en on the first ready: the slave may keep toggling ready.
          if (bus.m_ready) begin
            state          <= RESP;
            bus.m_en       <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= bus.m_wr ? '0 : bus.m_rdata;
          end else begin
`ifdef RV32_PERIPH_MASTER_TIMEOUT_EN
            if (cnt == CNTW'(TIMEOUT)) begin
              state          <= RESP;
              bus.m_en       <= 1'b0;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
`endif
          end
        end

        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            busy           <= 1'b0;
          end
        end

        default: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.m_en       <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_periph_master.sv
// Randomized and directed bench for rv32_periph_master with a behavioural slave and response model.
module tb_rv32_periph_master;
  localparam int ADDRW = 16;
  localparam int XLEN  = 32;

  logic CLK;
  logic RST_N;
  logic busy;

  int checks = 0;
  int passed = 0;

  rv32_periph_master_if #(.ADDRW(ADDRW), .XLEN(XLEN)) bus ();

  rv32_periph_master #(.ADDRW(ADDRW), .XLEN(XLEN), .TIMEOUT(4)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.master),
    .busy (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Slave contents: a fixed pattern per word address, perturbed by a salt.
  function automatic logic [31:0] model_rdata(input logic [15:0] addr, input logic [31:0] salt);
    return {addr, ~addr} ^ salt ^ 32'h5A5A_0000;
  endfunction

  // Slave: ready arrives slave_lat cycles after the first m_en cycle; noise while idle.
  int          slave_lat = 1;
  logic [31:0] salt = '0;
  int          en_age = 0;
  bit          noise = 1'b1;

  always @(negedge CLK) begin
    if (bus.m_en) begin
      if (en_age == slave_lat) begin
        bus.m_ready = 1'b1;
        bus.m_rdata = model_rdata(bus.m_addr, salt);
      end else begin
        bus.m_ready = 1'b0;
        bus.m_rdata = $urandom;
      end
      en_age++;
    end else begin
      en_age      = 0;
      bus.m_ready = noise ? 1'($urandom % 2) : 1'b0;
      bus.m_rdata = $urandom;
    end
  end

  // Bus monitor: records each access and the gaps between them.
  int          en_cycles = 0;
  int          n_access = 0;
  int          gap_cnt = 1000;
  int          min_gap = 1000;
  bit          prev_en = 1'b0;
  bit          field_change = 1'b0;
  logic        rec_wr;
  logic [15:0] rec_addr;
  logic [31:0] rec_wdata;
  logic [3:0]  rec_strb;

  always @(negedge CLK) begin
    if (bus.m_en) begin
      if (!prev_en) begin
        n_access++;
        en_cycles = 1;
        rec_wr    = bus.m_wr;
        rec_addr  = bus.m_addr;
        rec_wdata = bus.m_wdata;
        rec_strb  = bus.m_strb;
        if (gap_cnt < min_gap) min_gap = gap_cnt;
      end else begin
        en_cycles++;
        if (bus.m_wr !== rec_wr || bus.m_addr !== rec_addr ||
            bus.m_wdata !== rec_wdata || bus.m_strb !== rec_strb)
          field_change = 1'b1;
      end
    end else begin
      if (prev_en) gap_cnt = 1;
      else gap_cnt++;
    end
    prev_en = bus.m_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus driver; called at a negedge with the DUT idle, returns at a negedge with it idle.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output bit to, output bit unstable, output bit rr_high);
    int n;
    to = 0; unstable = 0; rr_high = 0; rdata = 'x; err = 1'bx;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge CLK); n++; end
    if (!bus.req_ready) to = 1;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 50) begin @(negedge CLK); lat++; end
    if (!bus.resp_valid) begin
      to = 1;
      return;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    if (bus.req_ready) rr_high = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      if (!bus.resp_valid || bus.resp_rdata !== rdata || bus.resp_err !== err) unstable = 1;
      if (bus.req_ready) rr_high = 1;
    end
    bus.resp_ready = 1'b1;
    @(negedge CLK);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_req_ready got=%0b exp=1", bus.req_ready); else passed++;
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%0b exp=0", bus.resp_valid); else passed++;
    checks++; if (bus.m_en !== 1'b0) $display("FAIL rst_m_en got=%0b exp=0", bus.m_en); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy); else passed++;
    checks++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0)
      $display("FAIL rst_resp got=%h/%0b exp=0/0", bus.resp_rdata, bus.resp_err); else passed++;
    checks++; if (bus.m_wr !== 1'b0 || bus.m_addr !== 16'h0 || bus.m_wdata !== 32'h0 || bus.m_strb !== 4'h0)
      $display("FAIL rst_bus got=%0b/%h/%h/%h exp=0", bus.m_wr, bus.m_addr, bus.m_wdata, bus.m_strb); else passed++;
  endtask

  task automatic test_store();
    logic [31:0] rd; logic er; int lat; bit to, us, rr; int acc0;
    slave_lat = 1; field_change = 0; acc0 = n_access;
    issue(1'b1, 16'h000C, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat, to, us, rr);
    checks++; if (to) $display("FAIL store_timeout got=1 exp=0"); else passed++;
    checks++; if (lat !== 3) $display("FAIL store_latency got=%0d exp=3", lat); else passed++;
    checks++; if (er !== 1'b0 || rd !== 32'h0) $display("FAIL store_resp got=%0b/%h exp=0/0", er, rd); else passed++;
    checks++; if (n_access - acc0 !== 1) $display("FAIL store_accesses got=%0d exp=1", n_access - acc0); else passed++;
    checks++; if (en_cycles !== 2) $display("FAIL store_en_cycles got=%0d exp=2", en_cycles); else passed++;
    checks++; if (rec_wr !== 1'b1 || rec_addr !== 16'h000C || rec_wdata !== 32'hDEAD_BEEF || rec_strb !== 4'hF)
      $display("FAIL store_fields got=%0b/%h/%h/%h exp=1/000c/deadbeef/f", rec_wr, rec_addr, rec_wdata, rec_strb); else passed++;
    checks++; if (field_change) $display("FAIL store_stable got=changed exp=stable"); else passed++;
  endtask

  task automatic test_load();
    logic [31:0] rd; logic er; int lat; bit to, us, rr;
    slave_lat = 1; field_change = 0;
    salt = 32'h1234_5678 ^ model_rdata(16'h0004, 32'h0);
    issue(1'b0, 16'h0004, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat, to, us, rr);
    checks++; if (rd !== 32'h1234_5678 || er !== 1'b0) $display("FAIL load_resp got=%h/%0b exp=12345678/0", rd, er); else passed++;
    checks++; if (lat !== 3) $display("FAIL load_latency got=%0d exp=3", lat); else passed++;
    checks++; if (rec_wr !== 1'b0 || rec_strb !== 4'h0 || rec_addr !== 16'h0004)
      $display("FAIL load_fields got=%0b/%h/%h exp=0/0/0004", rec_wr, rec_strb, rec_addr); else passed++;
    checks++; if (en_cycles !== 2 || field_change) $display("FAIL load_en got=%0d/%0b exp=2/0", en_cycles, field_change); else passed++;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat; bit to, us, rr; int acc0;
    acc0 = n_access;
    issue(1'b0, 16'h0006, 32'h0, 4'h0, 0, rd, er, lat, to, us, rr);
    checks++; if (n_access - acc0 !== 0) $display("FAIL misal_access got=%0d exp=0", n_access - acc0); else passed++;
    checks++; if (lat !== 1) $display("FAIL misal_latency got=%0d exp=1", lat); else passed++;
    checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL misal_resp got=%0b/%h exp=1/0", er, rd); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; bit to, us, rr; int acc0;
    slave_lat = 1; min_gap = 1000; acc0 = n_access; salt = $urandom;
    issue(1'b0, 16'h0020, 32'h0, 4'h0, 5, rd, er, lat, to, us, rr);
    checks++; if (us || rr) $display("FAIL b2b_hold1 got=unstable%0b/ready%0b exp=0/0", us, rr); else passed++;
    checks++; if (rd !== model_rdata(16'h0020, salt)) $display("FAIL b2b_rdata got=%h exp=%h", rd, model_rdata(16'h0020, salt)); else passed++;
    issue(1'b1, 16'h0024, 32'hCAFE_F00D, 4'h0, 5, rd, er, lat, to, us, rr);
    checks++; if (us || rr) $display("FAIL b2b_hold2 got=unstable%0b/ready%0b exp=0/0", us, rr); else passed++;
    checks++; if (n_access - acc0 !== 2) $display("FAIL b2b_accesses got=%0d exp=2", n_access - acc0); else passed++;
    checks++; if (min_gap < 2) $display("FAIL b2b_gap got=%0d exp=>=2", min_gap); else passed++;
    checks++; if (rec_wr !== 1'b1 || rec_strb !== 4'h0 || rec_wdata !== 32'hCAFE_F00D || en_cycles !== 2)
      $display("FAIL zero_strb_store got=%0b/%h/%h/%0d exp=1/0/cafef00d/2", rec_wr, rec_strb, rec_wdata, en_cycles); else passed++;
    min_gap = 1000;
    issue(1'b0, 16'h0028, 32'h0, 4'h0, 0, rd, er, lat, to, us, rr);
    issue(1'b0, 16'h002C, 32'h0, 4'h0, 0, rd, er, lat, to, us, rr);
    checks++; if (min_gap !== 2) $display("FAIL b2b_min_gap got=%0d exp=2", min_gap); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lat; bit to, us, rr; int acc0;
    logic wr; logic [15:0] addr; logic [31:0] wdata; logic [3:0] strb; int hold; int sl;
    logic exp_err; logic [31:0] exp_rd;
    field_change = 0; min_gap = 1000;
    for (int k = 0; k < 40; k++) begin
      wr    = 1'($urandom % 2);
      addr  = 16'($urandom);
      if ($urandom % 4 != 0) addr[1:0] = 2'b00;
      wdata = $urandom;
      strb  = ($urandom % 5 == 0) ? 4'h0 : 4'($urandom);
      sl    = int'($urandom % 4);
      hold  = int'($urandom % 4);
      salt  = $urandom;
      slave_lat = sl;
      exp_err = (addr[1:0] != 2'b00);
      exp_rd  = (exp_err || wr) ? 32'h0 : model_rdata(addr, salt);
      acc0 = n_access;
      issue(wr, addr, wdata, strb, hold, rd, er, lat, to, us, rr);
      checks++; if (to || er !== exp_err || rd !== exp_rd)
        $display("FAIL rand%0d_resp got=%0b/%h exp=%0b/%h", k, er, rd, exp_err, exp_rd); else passed++;
      checks++; if (lat !== (exp_err ? 1 : sl + 2))
        $display("FAIL rand%0d_latency got=%0d exp=%0d", k, lat, exp_err ? 1 : sl + 2); else passed++;
      checks++; if (us || rr) $display("FAIL rand%0d_hold got=unstable%0b/ready%0b exp=0/0", k, us, rr); else passed++;
      checks++; if (n_access - acc0 !== (exp_err ? 0 : 1))
        $display("FAIL rand%0d_accesses got=%0d exp=%0d", k, n_access - acc0, exp_err ? 0 : 1); else passed++;
      if (!exp_err) begin
        checks++; if (en_cycles !== sl + 1 || rec_wr !== wr || rec_addr !== addr || rec_strb !== (wr ? strb : 4'h0))
          $display("FAIL rand%0d_bus got=%0d/%0b/%h/%h exp=%0d/%0b/%h/%h", k, en_cycles, rec_wr, rec_addr, rec_strb,
                   sl + 1, wr, addr, wr ? strb : 4'h0); else passed++;
        if (wr) begin
          checks++; if (rec_wdata !== wdata) $display("FAIL rand%0d_wdata got=%h exp=%h", k, rec_wdata, wdata); else passed++;
        end
      end
    end
    checks++; if (field_change) $display("FAIL rand_bus_stable got=changed exp=stable"); else passed++;
    checks++; if (min_gap < 2) $display("FAIL rand_gap got=%0d exp=>=2", min_gap); else passed++;
  endtask

`ifdef RV32_PERIPH_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd; logic er; int lat; bit to, us, rr;
    salt = $urandom;
    slave_lat = 1000;
    issue(1'b0, 16'h0030, 32'h0, 4'h0, 0, rd, er, lat, to, us, rr);
    checks++; if (en_cycles !== 5) $display("FAIL tmo_en_cycles got=%0d exp=5", en_cycles); else passed++;
    checks++; if (to || er !== 1'b1 || rd !== 32'h0 || lat !== 6)
      $display("FAIL tmo_resp got=%0b/%h/lat%0d exp=1/0/lat6", er, rd, lat); else passed++;
    slave_lat = 4;
    issue(1'b0, 16'h0034, 32'h0, 4'h0, 0, rd, er, lat, to, us, rr);
    checks++; if (en_cycles !== 5) $display("FAIL tmo_edge_en_cycles got=%0d exp=5", en_cycles); else passed++;
    checks++; if (to || er !== 1'b0 || rd !== model_rdata(16'h0034, salt) || lat !== 6)
      $display("FAIL tmo_edge_resp got=%0b/%h/lat%0d exp=0/%h/lat6", er, rd, lat, model_rdata(16'h0034, salt)); else passed++;
  endtask
`endif

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; int lat; bit to, us, rr; int n;
    slave_lat = 1000;
    bus.req_wr = 1'b0; bus.req_addr = 16'h0040; bus.req_wdata = '0; bus.req_strb = '0;
    bus.req_valid = 1'b1;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.m_en && n < 20) begin @(negedge CLK); n++; end
    @(negedge CLK);
    checks++; if (bus.m_en !== 1'b1 || busy !== 1'b1) $display("FAIL rstmid_pre got=%0b/%0b exp=1/1", bus.m_en, busy); else passed++;
    RST_N = 1'b0;
    #1;
    checks++; if (bus.m_en !== 1'b0 || bus.resp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstmid_async got=%0b/%0b/%0b exp=0/0/0", bus.m_en, bus.resp_valid, busy); else passed++;
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK); @(negedge CLK);
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
      $display("FAIL rstmid_after got=%0b/%0b exp=1/0", bus.req_ready, bus.resp_valid); else passed++;
    slave_lat = 1; salt = $urandom;
    issue(1'b0, 16'h0044, 32'h0, 4'h0, 0, rd, er, lat, to, us, rr);
    checks++; if (to || er !== 1'b0 || rd !== model_rdata(16'h0044, salt) || lat !== 3)
      $display("FAIL rstmid_load got=%0b/%h/lat%0d exp=0/%h/lat3", er, rd, lat, model_rdata(16'h0044, salt)); else passed++;
  endtask

  initial begin
    RST_N = 1'b0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_strb = '0;
    bus.resp_ready = 1'b0; bus.m_ready = 1'b0; bus.m_rdata = '0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_back_to_back();
    test_random();
`ifdef RV32_PERIPH_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
